// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic                  dm_req;
    logic                  dm_we;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_sel;
    logic                  mem_req;
    logic                  mem_we;
    logic                  if_done;
    logic                  dm_done;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    modport master (
        output if_req, dm_req, dm_we, mem_ack, mem_rdata,
        input  mem_sel, mem_req, mem_we, if_done, dm_done,
        input  err, rdata, busy
    );

    modport slave (
        input  if_req, dm_req, dm_we, mem_ack, mem_rdata,
        output mem_sel, mem_req, mem_we, if_done, dm_done,
        output err, rdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: ties go to the requester that did not win last.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = req[1] ? SEL_DM : SEL_IF;
        if (req == 2'b11)
            winner = ~last;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data with round-robin
// grants, per-access sequencing and an optional wait timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic                  if_done_q, if_done_d;
    logic                  dm_done_q, dm_done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  last_q, last_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req    ({bus.dm_req, bus.if_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        req_d     = req_q;
        we_d      = we_q;
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        unique case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                cnt_d = '0;
                if (pick_valid) begin
                    sel_d   = pick_winner;
                    we_d    = pick_winner & bus.dm_we;
                    last_d  = pick_winner;
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ack) begin
                    rdata_d   = bus.mem_rdata;
                    err_d     = 1'b0;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    if_done_d = (sel_q == SEL_IF);
                    dm_done_d = (sel_q == SEL_DM);
                    state_d   = ST_DONE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    if_done_d = (sel_q == SEL_IF);
                    dm_done_d = (sel_q == SEL_DM);
                    state_d   = ST_DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last resets to DM so the first tie after reset goes to fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_IF;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            last_q    <= SEL_DM;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            we_q      <= we_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign bus.mem_sel = sel_q;
    assign bus.mem_req = req_q;
    assign bus.mem_we  = we_q;
    assign bus.if_done = if_done_q;
    assign bus.dm_done = dm_done_q;
    assign bus.err     = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations,
// immediate assertions at each check.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH (32),
        .TIMEOUT    (16),
        .CNT_WIDTH  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp_sel [4];
        checks   = 0;
        failures = 0;
        exp_sel[0] = 1'b0;
        exp_sel[1] = 1'b1;
        exp_sel[2] = 1'b0;
        exp_sel[3] = 1'b1;

        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        cyc();
        cyc();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_sel", bus.mem_sel, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_if_done", bus.if_done, 1'b0);
        chk1("rst_dm_done", bus.dm_done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk32("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        cyc();

        // single fetch, zero-wait ack
        bus.if_req = 1'b1;
        cyc();
        chk1("t1_mem_req", bus.mem_req, 1'b1);
        chk1("t1_mem_sel", bus.mem_sel, 1'b0);
        chk1("t1_mem_we", bus.mem_we, 1'b0);
        chk1("t1_busy", bus.busy, 1'b1);
        chk1("t1_no_early_done", bus.if_done, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk1("t1_if_done", bus.if_done, 1'b1);
        chk1("t1_dm_done", bus.dm_done, 1'b0);
        chk1("t1_err", bus.err, 1'b0);
        chk32("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk1("t1_req_low", bus.mem_req, 1'b0);
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        cyc();
        chk1("t1_done_clear", bus.if_done, 1'b0);
        chk1("t1_idle", bus.busy, 1'b0);

        // spurious ack in IDLE
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        cyc();
        chk1("t6_busy", bus.busy, 1'b0);
        chk1("t6_mem_req", bus.mem_req, 1'b0);
        chk1("t6_if_done", bus.if_done, 1'b0);
        chk1("t6_dm_done", bus.dm_done, 1'b0);
        cyc();
        chk32("t6_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk1("t6_busy2", bus.busy, 1'b0);
        bus.mem_ack = 1'b0;

        // contention from reset, store on DM, two waits before ack
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_we  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk1($sformatf("t2_sel_%0d", k), bus.mem_sel, exp_sel[k][0]);
            chk1($sformatf("t2_we_%0d", k), bus.mem_we, exp_sel[k][0]);
            chk1($sformatf("t2_req_%0d", k), bus.mem_req, 1'b1);
            cyc();
            chk1($sformatf("t2_hold_%0d", k), bus.mem_sel, exp_sel[k][0]);
            cyc();
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h0000_00A0 + k;
            cyc();
            bus.mem_ack = 1'b0;
            chk1($sformatf("t2_ifd_%0d", k), bus.if_done, ~exp_sel[k][0]);
            chk1($sformatf("t2_dmd_%0d", k), bus.dm_done, exp_sel[k][0]);
            chk32($sformatf("t2_rd_%0d", k), bus.rdata, 32'h0000_00A0 + k);
            chk1($sformatf("t2_we_off_%0d", k), bus.mem_we, 1'b0);
            if (k == 3) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
                bus.dm_we  = 1'b0;
            end
            cyc();
            chk1($sformatf("t2_idle_%0d", k), bus.busy, 1'b0);
        end

        // timeout with no ack
        bus.dm_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.mem_req) n++;
            else break;
        end
        chk32("t3_req_cycles", n, 32'd16);
        chk1("t3_dm_done", bus.dm_done, 1'b1);
        chk1("t3_err", bus.err, 1'b1);
        chk32("t3_rdata", bus.rdata, 32'h0);
        chk1("t3_busy_done", bus.busy, 1'b1);
        bus.dm_req = 1'b0;
        cyc();
        chk1("t3_busy_after", bus.busy, 1'b0);
        chk1("t3_err_clear", bus.err, 1'b0);
        chk1("t3_dm_done_clear", bus.dm_done, 1'b0);

        // fetch drops request after grant; access still completes
        bus.if_req = 1'b1;
        cyc();
        chk1("t4_sel", bus.mem_sel, 1'b0);
        chk1("t4_req", bus.mem_req, 1'b1);
        bus.if_req = 1'b0;
        cyc();
        chk1("t4_still_req", bus.mem_req, 1'b1);
        cyc();
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_0004;
        cyc();
        bus.mem_ack = 1'b0;
        chk1("t4_if_done", bus.if_done, 1'b1);
        chk32("t4_rdata", bus.rdata, 32'hCAFE_0004);
        cyc();
        chk1("t4_pulse_once", bus.if_done, 1'b0);
        cyc();
        chk1("t4_stay_idle", bus.busy, 1'b0);

        // async reset mid-WAIT, then tie goes to fetch
        bus.dm_req = 1'b1;
        cyc();
        chk1("t5_dm_granted", bus.mem_sel, 1'b1);
        chk1("t5_in_wait", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t5_req_async", bus.mem_req, 1'b0);
        chk1("t5_busy_async", bus.busy, 1'b0);
        chk1("t5_sel_async", bus.mem_sel, 1'b0);
        bus.dm_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        cyc();
        chk1("t5_tie_if", bus.mem_sel, 1'b0);
        chk1("t5_tie_req", bus.mem_req, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        cyc();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        bus.dm_req  = 1'b0;
        chk1("t5_if_done", bus.if_done, 1'b1);
        cyc();
        chk1("t5_idle", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
